// File: rtl/rv32i_pkg.sv
// Shared RV32I fetch definitions: FSM state type, NOP encoding, default reset vector.
package rv32i_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

    // Only bit 1 matters: bit 0 is allowed through for jal/branch targets.
    function automatic logic pc_misaligned(input logic [31:0] pc);
        return pc[1];
    endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-pc selection: jalr > jal > branch > sequential.
module next_pc_sel
    import rv32i_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] pc_target,
    input  logic        jal,
    input  logic        jalr,
    input  logic        branch_taken,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    // The decoder raises jal together with jalr for JALR, so jalr is checked first.
    always_comb begin
        next_pc = pc + 32'd4;
        if (jalr) begin
            next_pc = {pc_target[31:1], 1'b0};
        end else if (jal || branch_taken) begin
            next_pc = pc_target;
        end
    end

    assign misaligned = pc_misaligned(next_pc);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: one outstanding request, holds the fetched word until the
// core retires it, then redirects or advances the pc. Timeouts and misaligned
// targets park the unit in a sticky fault state until reset.
module instr_fetch
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter int unsigned TIMEOUT      = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_code,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        core_ready,
    input  logic        branch_taken,
    input  logic        jal,
    input  logic        jalr,
    input  logic [31:0] pc_target,
    output logic        fetch_fault,
    output logic [31:0] retired_cnt
);

    // The wait counter only needs to reach TIMEOUT-1.
    localparam int unsigned    CntW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    fetch_state_t    state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     code_q, code_d;
    logic [31:0]     ipc_q, ipc_d;
    logic [31:0]     retired_q, retired_d;
    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
    logic            req_q, req_d;

    logic [31:0]     next_pc;
    logic            next_misaligned;

    next_pc_sel u_next_pc_sel (
        .pc           (pc_q),
        .pc_target    (pc_target),
        .jal          (jal),
        .jalr         (jalr),
        .branch_taken (branch_taken),
        .next_pc      (next_pc),
        .misaligned   (next_misaligned)
    );

    // Next-state logic. req_q is registered so it stays low while in reset; right
    // after reset FETCH spends one cycle raising it, afterwards it is raised on the
    // HOLD->FETCH transition so FETCH lasts exactly one cycle.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        code_d     = code_q;
        ipc_d      = ipc_q;
        retired_d  = retired_q;
        wait_cnt_d = wait_cnt_q;
        req_d      = 1'b0;

        unique case (state_q)
            FETCH: begin
                if (req_q) begin
                    state_d    = WAIT;
                    wait_cnt_d = '0;
                end else begin
                    req_d = 1'b1;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    code_d  = imem_rdata;
                    ipc_d   = pc_q;
                    state_d = HOLD;
                end else if (wait_cnt_q == CntLast) begin
                    state_d = FAULT;
                end else begin
                    wait_cnt_d = wait_cnt_q + CntW'(1);
                end
            end
            HOLD: begin
                if (core_ready) begin
                    retired_d = retired_q + 32'd1;
                    // A misaligned target is kept in pc for post-mortem.
                    pc_d      = next_pc;
                    if (next_misaligned) begin
                        state_d = FAULT;
                    end else begin
                        state_d = FETCH;
                        req_d   = 1'b1;
                    end
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = FAULT;
            end
        endcase
    end

    // All fetch state, asynchronously cleared.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= FETCH;
            pc_q       <= RESET_VECTOR;
            code_q     <= NOP_INSTR;
            ipc_q      <= RESET_VECTOR;
            retired_q  <= 32'd0;
            wait_cnt_q <= '0;
            req_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            code_q     <= code_d;
            ipc_q      <= ipc_d;
            retired_q  <= retired_d;
            wait_cnt_q <= wait_cnt_d;
            req_q      <= req_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr_code  = code_q;
    assign instr_pc    = ipc_q;
    assign instr_valid = (state_q == HOLD);
    assign fetch_fault = (state_q == FAULT);
    assign retired_cnt = retired_q;

endmodule
